// File: rtl/shadow_pkg.sv
// Shared constants, types and the fixed GPR <-> shadow-index mapping
// for the caller-saved shadow register bank.
package shadow_pkg;

    localparam int         NR_SHADOW_REGS = 16;
    localparam int         SHADOW_IDX_W   = $clog2(NR_SHADOW_REGS);
    localparam logic [4:0] GPR_SP         = 5'd2;

    typedef logic [SHADOW_IDX_W-1:0] shadow_idx_t;

    typedef enum logic {IDLE, XFER} xfer_state_e;

    typedef struct packed {
        logic        hit;
        shadow_idx_t idx;
    } shadow_lookup_t;

    // Shadow order: ra, t0-t2, a0-a7, t3-t6
    function automatic logic [4:0] shadow_idx_to_gpr(input shadow_idx_t idx);
        logic [4:0] gpr;
        if (idx == shadow_idx_t'(0))       gpr = 5'd1;
        else if (idx < shadow_idx_t'(4))   gpr = 5'd4 + {1'b0, idx};
        else if (idx < shadow_idx_t'(12))  gpr = 5'd6 + {1'b0, idx};
        else                               gpr = 5'd16 + {1'b0, idx};
        return gpr;
    endfunction

    function automatic shadow_lookup_t gpr_to_shadow_idx(input logic [4:0] gpr);
        shadow_lookup_t res;
        res = '0;
        if (gpr == 5'd1) begin
            res.hit = 1'b1;
        end else if (gpr >= 5'd5 && gpr <= 5'd7) begin
            res.hit = 1'b1;
            res.idx = shadow_idx_t'(gpr - 5'd4);
        end else if (gpr >= 5'd10 && gpr <= 5'd17) begin
            res.hit = 1'b1;
            res.idx = shadow_idx_t'(gpr - 5'd6);
        end else if (gpr >= 5'd28) begin
            res.hit = 1'b1;
            res.idx = shadow_idx_t'(gpr - 5'd16);
        end
        return res;
    endfunction

endpackage

// File: rtl/shadow_bank.sv
// Register array with synchronous reset, whole-array load, one write port
// and a combinational read port that returns 0 outside the array.
module shadow_bank #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64,
    parameter int AW    = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        load_i,
    input  logic [DEPTH-1:0][WIDTH-1:0] load_data_i,
    input  logic                        we_i,
    input  logic [AW-1:0]               waddr_i,
    input  logic [WIDTH-1:0]            wdata_i,
    input  logic [AW-1:0]               raddr_i,
    output logic [WIDTH-1:0]            rdata_o,
    output logic [DEPTH-1:0][WIDTH-1:0] q_o
);

    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic                        waddr_ok;
    logic                        raddr_ok;

    assign waddr_ok = {1'b0, waddr_i} < (AW+1)'(DEPTH);
    assign raddr_ok = {1'b0, raddr_i} < (AW+1)'(DEPTH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '0;
        end else begin
            if (load_i) mem_q <= load_data_i;
            // The single-entry write follows the load so it wins on its index.
            if (we_i && waddr_ok) mem_q[waddr_i[IW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = raddr_ok ? mem_q[raddr_i[IW-1:0]] : '0;
    assign q_o     = mem_q;

endmodule

// File: rtl/shadow_regfile_bank.sv
// Live/save/restore shadow banks for the caller-saved GPRs plus the
// sequencer that drains the restore bank into the architectural regfile.
//
// state | meaning
// IDLE  | mirroring commits; restore bank writable
// XFER  | writing restore bank back to the arch regfile, one index per cycle
module shadow_regfile_bank import shadow_pkg::*; #(
    parameter int NR_SHADOW_REGS  = shadow_pkg::NR_SHADOW_REGS,
    parameter int ADDR_WIDTH      = 5,
    parameter int DATA_WIDTH      = 64,
    parameter int NR_COMMIT_PORTS = 2
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic [NR_COMMIT_PORTS-1:0]                  commit_we_i,
    input  logic [NR_COMMIT_PORTS-1:0][4:0]             commit_waddr_i,
    input  logic [NR_COMMIT_PORTS-1:0][DATA_WIDTH-1:0]  commit_wdata_i,
    input  logic                                        snapshot_i,
    input  logic [ADDR_WIDTH-1:0]                       save_raddr_i,
    output logic [DATA_WIDTH-1:0]                       save_rdata_o,
    output logic [DATA_WIDTH-1:0]                       sp_o,
    input  logic                                        restore_we_i,
    input  logic [ADDR_WIDTH-1:0]                       restore_waddr_i,
    input  logic [DATA_WIDTH-1:0]                       restore_wdata_i,
    input  logic                                        shadow_load_i,
    output logic                                        arch_we_o,
    output logic [4:0]                                  arch_waddr_o,
    output logic [DATA_WIDTH-1:0]                       arch_wdata_o,
    output logic                                        xfer_busy_o,
    output logic                                        xfer_done_o
);

    localparam shadow_idx_t LAST_IDX = shadow_idx_t'(NR_SHADOW_REGS - 1);

    typedef logic [NR_SHADOW_REGS-1:0][DATA_WIDTH-1:0] bank_t;

    xfer_state_e                state_q;
    shadow_idx_t                idx_q;
    shadow_idx_t                rd_idx;
    logic [NR_SHADOW_REGS-1:0]  valid_q;
    logic                       arch_we_q;
    logic [4:0]                 arch_waddr_q;
    logic [DATA_WIDTH-1:0]      arch_wdata_q;
    logic                       busy_q;
    logic                       done_q;
    logic [DATA_WIDTH-1:0]      sp_q;
    logic [DATA_WIDTH-1:0]      sp_d;

    bank_t                      live_q;
    bank_t                      live_commit;
    bank_t                      snap_data;
    logic                       commit_hit;
    shadow_lookup_t             lookup;
    logic                       xfer_live_we;
    logic                       issue;
    logic                       restore_hit;
    logic [DATA_WIDTH-1:0]      restore_rdata;

    logic [DATA_WIDTH-1:0]      live_rdata_unused;
    bank_t                      save_q_unused;
    bank_t                      restore_q_unused;

    // The mirror follows what actually lands in the arch regfile.
    assign xfer_live_we = (state_q == XFER) && arch_we_q;
    assign rd_idx       = (state_q == IDLE) ? '0 : idx_q + shadow_idx_t'(1);
    assign issue        = ((state_q == IDLE) && shadow_load_i) ||
                          ((state_q == XFER) && (idx_q != LAST_IDX));
    assign restore_hit  = restore_we_i && (state_q == IDLE) &&
                          ({1'b0, restore_waddr_i} < (ADDR_WIDTH+1)'(NR_SHADOW_REGS));

    always_comb begin
        live_commit = live_q;
        sp_d        = sp_q;
        commit_hit  = 1'b0;
        lookup      = '0;
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            if (commit_we_i[p]) begin
                lookup = gpr_to_shadow_idx(commit_waddr_i[p]);
                if (lookup.hit) begin
                    live_commit[lookup.idx] = commit_wdata_i[p];
                    commit_hit              = 1'b1;
                end
                if (commit_waddr_i[p] == GPR_SP) sp_d = commit_wdata_i[p];
            end
        end
        snap_data = live_commit;
        if (xfer_live_we) snap_data[idx_q] = arch_wdata_q;
    end

    shadow_bank #(.DEPTH(NR_SHADOW_REGS), .WIDTH(DATA_WIDTH), .AW(ADDR_WIDTH)) u_live (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (commit_hit),
        .load_data_i(live_commit),
        .we_i       (xfer_live_we),
        .waddr_i    (ADDR_WIDTH'(idx_q)),
        .wdata_i    (arch_wdata_q),
        .raddr_i    ('0),
        .rdata_o    (live_rdata_unused),
        .q_o        (live_q)
    );

    shadow_bank #(.DEPTH(NR_SHADOW_REGS), .WIDTH(DATA_WIDTH), .AW(ADDR_WIDTH)) u_save (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (snapshot_i),
        .load_data_i(snap_data),
        .we_i       (1'b0),
        .waddr_i    ('0),
        .wdata_i    ('0),
        .raddr_i    (save_raddr_i),
        .rdata_o    (save_rdata_o),
        .q_o        (save_q_unused)
    );

    shadow_bank #(.DEPTH(NR_SHADOW_REGS), .WIDTH(DATA_WIDTH), .AW(ADDR_WIDTH)) u_restore (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (1'b0),
        .load_data_i('0),
        .we_i       (restore_hit),
        .waddr_i    (restore_waddr_i),
        .wdata_i    (restore_wdata_i),
        .raddr_i    (ADDR_WIDTH'(rd_idx)),
        .rdata_o    (restore_rdata),
        .q_o        (restore_q_unused)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            valid_q      <= '0;
            arch_we_q    <= 1'b0;
            arch_waddr_q <= '0;
            arch_wdata_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            if (restore_hit) valid_q[restore_waddr_i[SHADOW_IDX_W-1:0]] <= 1'b1;
            if (issue) begin
                state_q      <= XFER;
                idx_q        <= rd_idx;
                arch_we_q    <= valid_q[rd_idx];
                arch_waddr_q <= shadow_idx_to_gpr(rd_idx);
                arch_wdata_q <= restore_rdata;
                busy_q       <= 1'b1;
                done_q       <= (rd_idx == LAST_IDX);
            end else if (state_q == XFER) begin
                state_q   <= IDLE;
                arch_we_q <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
                valid_q   <= '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) sp_q <= '0;
        else       sp_q <= sp_d;
    end

    assign sp_o         = sp_q;
    assign arch_we_o    = arch_we_q;
    assign arch_waddr_o = arch_waddr_q;
    assign arch_wdata_o = arch_wdata_q;
    assign xfer_busy_o  = busy_q;
    assign xfer_done_o  = done_q;

    // A save sequence spans many cycles, so back-to-back snapshots mean a re-snapshot mid-save.
    a_no_resnapshot: assert property (@(posedge clk_i) disable iff (rst_i)
        snapshot_i |=> !snapshot_i);
    a_no_restore_in_xfer: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == XFER) |-> !restore_we_i);
    a_no_load_in_xfer: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == XFER) |-> !shadow_load_i);
    a_no_commit_in_xfer: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == XFER) |-> !(|commit_we_i));

endmodule

// File: tb/tb_shadow_regfile_bank.sv
// Directed bench for shadow_regfile_bank: vector table for mirror/snapshot,
// hand-written sequences for restore transfers and mid-transfer reset.
module tb_shadow_regfile_bank;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [1:0]       commit_we_i;
    logic [1:0][4:0]  commit_waddr_i;
    logic [1:0][63:0] commit_wdata_i;
    logic             snapshot_i;
    logic [4:0]       save_raddr_i;
    logic [63:0]      save_rdata_o;
    logic [63:0]      sp_o;
    logic             restore_we_i;
    logic [4:0]       restore_waddr_i;
    logic [63:0]      restore_wdata_i;
    logic             shadow_load_i;
    logic             arch_we_o;
    logic [4:0]       arch_waddr_o;
    logic [63:0]      arch_wdata_o;
    logic             xfer_busy_o;
    logic             xfer_done_o;

    shadow_regfile_bank dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .commit_we_i    (commit_we_i),
        .commit_waddr_i (commit_waddr_i),
        .commit_wdata_i (commit_wdata_i),
        .snapshot_i     (snapshot_i),
        .save_raddr_i   (save_raddr_i),
        .save_rdata_o   (save_rdata_o),
        .sp_o           (sp_o),
        .restore_we_i   (restore_we_i),
        .restore_waddr_i(restore_waddr_i),
        .restore_wdata_i(restore_wdata_i),
        .shadow_load_i  (shadow_load_i),
        .arch_we_o      (arch_we_o),
        .arch_waddr_o   (arch_waddr_o),
        .arch_wdata_o   (arch_wdata_o),
        .xfer_busy_o    (xfer_busy_o),
        .xfer_done_o    (xfer_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  a0;
        logic [63:0] d0;
        logic [4:0]  a1;
        logic [63:0] d1;
        logic        snap;
        logic [4:0]  raddr;
        logic [63:0] exp_rdata;
        logic [63:0] exp_sp;
    } vec_t;

    int unsigned gpr_map [16] = '{1, 5, 6, 7, 10, 11, 12, 13, 14, 15, 16, 17, 28, 29, 30, 31};

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        commit_we_i     = '0;
        commit_waddr_i  = '0;
        commit_wdata_i  = '0;
        snapshot_i      = 1'b0;
        save_raddr_i    = '0;
        restore_we_i    = 1'b0;
        restore_waddr_i = '0;
        restore_wdata_i = '0;
        shadow_load_i   = 1'b0;
    endtask

    task automatic restore_write(input int idx, input logic [63:0] val);
        restore_we_i    = 1'b1;
        restore_waddr_i = 5'(idx);
        restore_wdata_i = val;
        @(negedge clk_i);
        restore_we_i    = 1'b0;
    endtask

    // Starts at a negedge; pulses shadow_load_i and checks all 16 transfer cycles.
    task automatic run_xfer(input logic [15:0] exp_valid, input logic [63:0] base);
        shadow_load_i = 1'b1;
        @(negedge clk_i);
        shadow_load_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("xfer_we[%0d]", i), 64'(arch_we_o), 64'(exp_valid[i]));
            check($sformatf("xfer_busy[%0d]", i), 64'(xfer_busy_o), 64'd1);
            check($sformatf("xfer_done[%0d]", i), 64'(xfer_done_o), 64'(i == 15));
            if (exp_valid[i]) begin
                check($sformatf("xfer_waddr[%0d]", i), 64'(arch_waddr_o), 64'(gpr_map[i]));
                check($sformatf("xfer_wdata[%0d]", i), arch_wdata_o, base + 64'(i));
            end
            @(negedge clk_i);
        end
        check("post_xfer_busy", 64'(xfer_busy_o), 64'd0);
        check("post_xfer_we", 64'(arch_we_o), 64'd0);
        check("post_xfer_done", 64'(xfer_done_o), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [13];
        vecs[0]  = '{2'b01, 5'd10, 64'hA5,          5'd0,  64'h0,   1'b0, 5'd4,  64'h0,    64'h0};
        vecs[1]  = '{2'b00, 5'd0,  64'h0,           5'd0,  64'h0,   1'b1, 5'd4,  64'hA5,   64'h0};
        vecs[2]  = '{2'b01, 5'd2,  64'h8000_1000,   5'd0,  64'h0,   1'b0, 5'd4,  64'hA5,   64'h8000_1000};
        vecs[3]  = '{2'b11, 5'd5,  64'h1,           5'd5,  64'h2,   1'b1, 5'd1,  64'h2,    64'h8000_1000};
        vecs[4]  = '{2'b11, 5'd3,  64'hDEAD,        5'd0,  64'hBEEF, 1'b0, 5'd1, 64'h2,    64'h8000_1000};
        vecs[5]  = '{2'b00, 5'd0,  64'h0,           5'd0,  64'h0,   1'b1, 5'd4,  64'hA5,   64'h8000_1000};
        vecs[6]  = '{2'b00, 5'd0,  64'h0,           5'd0,  64'h0,   1'b0, 5'd3,  64'h0,    64'h8000_1000};
        vecs[7]  = '{2'b11, 5'd1,  64'h55,          5'd31, 64'h1234, 1'b1, 5'd15, 64'h1234, 64'h8000_1000};
        vecs[8]  = '{2'b11, 5'd2,  64'h42,          5'd2,  64'h99,  1'b0, 5'd0,  64'h55,   64'h99};
        vecs[9]  = '{2'b01, 5'd17, 64'h7,           5'd0,  64'h0,   1'b1, 5'd11, 64'h7,    64'h99};
        vecs[10] = '{2'b00, 5'd0,  64'h0,           5'd0,  64'h0,   1'b0, 5'd16, 64'h0,    64'h99};
        vecs[11] = '{2'b00, 5'd0,  64'h0,           5'd0,  64'h0,   1'b0, 5'd31, 64'h0,    64'h99};
        vecs[12] = '{2'b00, 5'd0,  64'h0,           5'd0,  64'h0,   1'b0, 5'd1,  64'h2,    64'h99};

        drive_idle();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rst_sp", sp_o, 64'h0);
        check("rst_arch_we", 64'(arch_we_o), 64'd0);
        check("rst_busy", 64'(xfer_busy_o), 64'd0);
        check("rst_done", 64'(xfer_done_o), 64'd0);
        check("rst_save0", save_rdata_o, 64'h0);
        rst_i = 1'b0;

        for (int v = 0; v < 13; v++) begin
            commit_we_i       = vecs[v].we;
            commit_waddr_i[0] = vecs[v].a0;
            commit_wdata_i[0] = vecs[v].d0;
            commit_waddr_i[1] = vecs[v].a1;
            commit_wdata_i[1] = vecs[v].d1;
            snapshot_i        = vecs[v].snap;
            save_raddr_i      = vecs[v].raddr;
            @(negedge clk_i);
            check($sformatf("vec%0d_save_rdata", v), save_rdata_o, vecs[v].exp_rdata);
            check($sformatf("vec%0d_sp", v), sp_o, vecs[v].exp_sp);
        end
        drive_idle();

        for (int i = 0; i < 16; i++) restore_write(i, 64'h100 + 64'(i));
        restore_write(20, 64'hBAD);
        run_xfer(16'hFFFF, 64'h100);

        // Transfer must have refreshed the live mirror.
        snapshot_i = 1'b1;
        @(negedge clk_i);
        snapshot_i   = 1'b0;
        save_raddr_i = 5'd0;
        #1 check("live_after_xfer_idx0", save_rdata_o, 64'h100);
        save_raddr_i = 5'd15;
        #1 check("live_after_xfer_idx15", save_rdata_o, 64'h10F);
        @(negedge clk_i);

        restore_write(3, 64'h333);
        run_xfer(16'h0008, 64'h330);
        run_xfer(16'h0000, 64'h0);

        for (int i = 0; i < 16; i++) restore_write(i, 64'h200 + 64'(i));
        shadow_load_i = 1'b1;
        @(negedge clk_i);
        shadow_load_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pre_rst_wdata[%0d]", i), arch_wdata_o, 64'h200 + 64'(i));
            @(negedge clk_i);
        end
        check("pre_rst_we4", 64'(arch_we_o), 64'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("post_rst_we[%0d]", i), 64'(arch_we_o), 64'd0);
            check($sformatf("post_rst_busy[%0d]", i), 64'(xfer_busy_o), 64'd0);
            @(negedge clk_i);
        end
        check("post_rst_sp", sp_o, 64'h0);
        for (int i = 0; i < 32; i++) begin
            save_raddr_i = 5'(i);
            #1 check($sformatf("post_rst_save[%0d]", i), save_rdata_o, 64'h0);
        end
        @(negedge clk_i);
        run_xfer(16'h0000, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shadow_regfile_bank.md
Name: shadow_regfile_bank

Overview:
- Holds the shadow copies of the 16 caller-saved GPRs (ra, t0-t2, a0-a7, t3-t6) for fast interrupt context handling.
- It consumes commit-stage GPR writes to keep a live mirror. On an interrupt it freezes a snapshot, which the shadow register controller reads and stores to the stack.
- It accepts restored values from the controller's load path. On mret it sequences them back into the architectural register file, one per cycle.
- It sits between commit and the regfile on one side, and the shadow register controller on the other.

Parameters:
- NR_SHADOW_REGS, 16, number of shadowed GPRs; fixed mapping via shadow_pkg::shadow_idx_to_gpr.
- ADDR_WIDTH, 5, shadow index width.
- DATA_WIDTH, 64, register width (XLEN).
- NR_COMMIT_PORTS, 2, commit write ports mirrored.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- commit_we_i  in  NR_COMMIT_PORTS  commit GPR write enables.
- commit_waddr_i  in  NR_COMMIT_PORTS x 5  commit GPR addresses.
- commit_wdata_i  in  NR_COMMIT_PORTS x DATA_WIDTH  commit write data.
- snapshot_i  in  1  save trigger from issue; pulse.
- save_raddr_i  in  ADDR_WIDTH  save-bank read index from the controller.
- save_rdata_o  out  DATA_WIDTH  save-bank read data; combinational.
- sp_o  out  DATA_WIDTH  live mirror of x2, fed to the controller's stack-pointer input.
- restore_we_i  in  1  restore-bank write enable from the controller.
- restore_waddr_i  in  ADDR_WIDTH  restore index.
- restore_wdata_i  in  DATA_WIDTH  restore data.
- shadow_load_i  in  1  start transfer from restore bank to arch regfile; pulse.
- arch_we_o  out  1  arch regfile write enable.
- arch_waddr_o  out  5  arch GPR address.
- arch_wdata_o  out  DATA_WIDTH  arch write data.
- xfer_busy_o  out  1  transfer in progress; stalls issue.
- xfer_done_o  out  1  one-cycle pulse on the last transfer cycle.

Behaviour:
- Reset (rst_i sampled high on a clock edge):
  - live, save and restore banks zeroed; restore valid bits cleared; sp_o = 0.
  - FSM goes to IDLE.
  - arch_we_o, xfer_busy_o and xfer_done_o all 0.
  - A reset during XFER aborts the transfer immediately; no further arch writes occur.
- Live mirror:
  - A commit write to a mapped GPR updates live[idx] at the next edge.
  - A write to x2 updates sp_o at the next edge.
  - Writes to x0 and to unmapped GPRs are ignored.
  - If several ports write the same register in one cycle, the highest port index wins (youngest).
- Snapshot:
  - On snapshot_i, save[i] <= live[i] for all i, with same-cycle commit writes bypassed in, so the snapshot includes that cycle's commits.
  - Saved values are visible on save_rdata_o the next cycle.
  - save_rdata_o = save[save_raddr_i]; it returns 0 for an index >= NR_SHADOW_REGS.
  - snapshot_i is legal in any state. The controller guarantees no re-snapshot while it is saving; an SVA checks this.
- Restore write:
  - restore_we_i writes restore[waddr] and sets valid[waddr].
  - An out-of-range index is ignored.
  - restore_we_i during XFER is illegal (SVA) and ignored.
- FSM:
  - IDLE -> XFER on shadow_load_i; the index counter resets to 0.
  - In XFER, for each cycle at index i:
    - arch_we_o = valid[i]; arch_waddr_o = shadow_idx_to_gpr(i); arch_wdata_o = restore[i].
    - live[i] is also updated with restore[i] so the mirror stays coherent.
    - The index increments each cycle.
  - At i = NR_SHADOW_REGS-1: xfer_done_o = 1, all valid bits are cleared, and the FSM returns to IDLE.
  - xfer_busy_o = 1 throughout XFER.
- Latency: if shadow_load_i is high at cycle t, the write for index i appears at cycle t+1+i, and the transfer lasts exactly NR_SHADOW_REGS cycles.
- shadow_load_i while in XFER: ignored (SVA).
- A commit write during XFER is illegal (SVA). If it occurs anyway, the XFER update to live wins on the same index.
- A snapshot during XFER captures live including that cycle's XFER write.

Decomposition:
- shadow_pkg holds:
  - the NR_SHADOW_REGS constant and the GPR_SP = 2 constant;
  - the function shadow_idx_to_gpr, giving the mapping {1,5,6,7,10..17,28..31};
  - the inverse function gpr_to_shadow_idx, which returns a hit flag plus the index;
  - the xfer_state_e enum {IDLE, XFER}.
- One sub-module, shadow_bank: a parameterised register array with one write port, a whole-array load input, a combinational read port and a synchronous reset. It is instantiated for the live, save and restore banks.

Test Plan:
- Reset, then commit x10 = 0xA5, then pulse snapshot_i -> save_raddr_i = 4 reads 0xA5 the next cycle; sp_o unchanged.
- In the same cycle, port0 writes x5 = 1, port1 writes x5 = 2, and snapshot_i is pulsed -> save[1] = 2 and live[1] = 2.
- Commit x2 = 0x8000_1000 -> sp_o = 0x8000_1000 one cycle later; commit x3 -> no bank changes.
- Restore idx 0..15 with value 0x100+i, then pulse shadow_load_i at t:
  - arch writes x1 = 0x100 at t+1, through x31 = 0x10F at t+16;
  - xfer_done_o at t+16; xfer_busy_o high t+1..t+16.
- Restore only idx 3, then transfer -> a single arch_we_o pulse at t+4 to x7; a second transfer produces no writes (valid bits cleared).
- Assert rst_i at t+5 mid-transfer -> arch_we_o = 0 from t+6 and the FSM is IDLE; save_rdata_o reads 0 for all indices.
